result_display: RTL and testbench

Drives a 4-digit multiplexed seven-segment display from the processor's 16-bit `result` output. It sits directly downstream of the processor core. The core holds `result` as a level with no strobe, so this block detects changes itself. On each change it converts the value sequentially to BCD (double-dabble, one bit per cycle) and time-multiplexes the digits onto active-low anode/segment pins.

---
 rtl/result_display_pkg.sv | 31 +++
 rtl/result_display_if.sv | 12 +
 rtl/result_display_bin2bcd.sv | 72 +++++++
 rtl/result_display.sv | 105 ++++++++++
 tb/tb_result_display.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/result_display_pkg.sv
// Shared types and constants for the result_display seven-segment driver.
package result_display_pkg;

  typedef enum logic [1:0] {StIdle, StShift, StCommit} conv_state_e;

  localparam int unsigned NUM_DIGITS  = 4;
  localparam int unsigned BCD_NIBBLES = 5;

  // Active-low {g,f,e,d,c,b,a}; element i is the glyph for nibble value i.
  localparam logic [15:0][6:0] SEG_PATTERNS = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/result_display_if.sv
// Display-side bundle: the value from the core and the pins/status driven back.
interface result_display_if;
  logic [15:0] result;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        busy;
  logic        ovf;

  modport master (output result, input an, seg, dp, busy, ovf);
  modport slave  (input result, output an, seg, dp, busy, ovf);
endinterface

// File: rtl/result_display_bin2bcd.sv
// Sequential double-dabble: one shift per cycle, 16 shifts, then a one-cycle done.
module result_display_bin2bcd
  import result_display_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [15:0]              value,
  output logic                     busy,
  output logic                     done,
  output logic [BCD_NIBBLES*4-1:0] bcd
);

  conv_state_e state_q, state_d;
  logic [35:0] sr_q, sr_d;  // {bcd[19:0], binary[15:0]}
  logic [3:0]  cnt_q, cnt_d;
  logic [19:0] adj;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StShift;
      StShift:  if (cnt_q == 4'd15) state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StCommit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    adj = '0;
    for (int i = 0; i < int'(BCD_NIBBLES); i++) begin
      adj[i*4 +: 4] = (sr_q[16+i*4 +: 4] >= 4'd5) ? sr_q[16+i*4 +: 4] + 4'd3
                                                  : sr_q[16+i*4 +: 4];
    end
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (state_q == StIdle && start) begin
      sr_d  = {20'd0, value};
      cnt_d = '0;
    end else if (state_q == StShift) begin
      // Top adjusted bit is always 0 for a 16-bit input, so dropping it is safe.
      sr_d  = {adj[18:0], sr_q[15:0], 1'b0};
      cnt_d = cnt_q + 4'd1;
    end
  end

  assign bcd = sr_q[35:16];

endmodule

// File: rtl/result_display.sv
// Four-digit multiplexed seven-segment driver for the core's result value.
// RESULT_DISPLAY_DECIMAL_EN selects BCD (decimal) display; otherwise raw hex nibbles.
module result_display
  import result_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic             clk,
  input  logic             rst,
  result_display_if.slave  bus
);

  localparam int unsigned DivW = $clog2(REFRESH_DIV);

  logic [15:0]                 last_value_q;
  logic [NUM_DIGITS-1:0][3:0]  digit_q;
  logic                        conv_busy;
  logic                        capture;
  logic                        ovf;
  logic [DivW-1:0]             div_q;
  logic [1:0]                  idx_q;
  logic [3:0]                  an_q;
  logic [6:0]                  seg_q;

  // result is a level, so a change against the last captured value is the trigger.
  assign capture = !conv_busy && (bus.result != last_value_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_value_q <= '0;
    end else if (capture) begin
      last_value_q <= bus.result;
    end
  end

`ifdef RESULT_DISPLAY_DECIMAL_EN
  logic                     conv_done;
  logic [BCD_NIBBLES*4-1:0] bcd;
  logic                     ovf_q;

  result_display_bin2bcd u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (capture),
    .value (bus.result),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (bcd)
  );

  // Only the ten-thousands nibble can signal overflow; four BCD digits never exceed 9999.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_q <= '0;
      ovf_q   <= 1'b0;
    end else if (conv_done) begin
      digit_q <= bcd[15:0];
      ovf_q   <= (bcd[19:16] != 4'd0);
    end
  end

  assign ovf = ovf_q;
`else
  logic load_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      load_q  <= 1'b0;
      digit_q <= '0;
    end else begin
      load_q <= capture;
      if (load_q) digit_q <= last_value_q;
    end
  end

  assign conv_busy = load_q;
  assign ovf       = 1'b0;
`endif

  // an and seg come from the same index register so they switch on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      idx_q <= '0;
      an_q  <= 4'b1111;
      seg_q <= SEG_BLANK;
    end else begin
      if (div_q == DivW'(REFRESH_DIV - 1)) begin
        div_q <= '0;
        idx_q <= idx_q + 2'd1;
      end else begin
        div_q <= div_q + DivW'(1);
      end
      an_q  <= ~(4'b0001 << idx_q);
      seg_q <= SEG_PATTERNS[digit_q[idx_q]];
    end
  end

  assign bus.an   = an_q;
  assign bus.seg  = seg_q;
  assign bus.dp   = 1'b1;
  assign bus.busy = conv_busy;
  assign bus.ovf  = ovf;

endmodule

// File: tb/tb_result_display.sv
// Self-checking bench for result_display; expectations follow RESULT_DISPLAY_DECIMAL_EN.
module tb_result_display;

  localparam int unsigned DIV = 4;
`ifdef RESULT_DISPLAY_DECIMAL_EN
  localparam bit DEC      = 1'b1;
  localparam int BUSY_LEN = 17;
`else
  localparam bit DEC      = 1'b0;
  localparam int BUSY_LEN = 1;
`endif

  typedef struct {
    logic [15:0] value;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;

  typedef struct packed {
    logic [15:0] digits;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  vec_t vecs[8];

  always #5 clk = ~clk;

  result_display_if bus ();

  result_display #(.REFRESH_DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_reset();
    check("rst_an", bus.an, 4'b1111);
    check("rst_seg", bus.seg, 7'b1111111);
    check("rst_dp", bus.dp, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_ovf", bus.ovf, 1'b0);
  endtask

  // Watch a full scan and compare the glyph seen at each anode position.
  task automatic read_digits(input string name, input logic [15:0] digits);
    logic [6:0] got[4];
    logic [3:0] sel;
    for (int i = 0; i < 4; i++) got[i] = 7'bx;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        sel    = 4'b1111;
        sel[i] = 1'b0;
        if (bus.an == sel) got[i] = bus.seg;
      end
    end
    for (int i = 0; i < 4; i++) check(name, got[i], seg_of(digits[i*4 +: 4]));
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, bus.busy, 1'b0);
  endtask

  task automatic run_vec(input logic [15:0] value, input logic [15:0] d, input logic o);
    exp_t e;
    int   n;
    bus.result = value;
    sb.push_back(exp_t'{d, o});
    @(negedge clk);
    check("busy_rise", bus.busy, 1'b1);
    n = 1;
    while (bus.busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("busy_len", n - 1, BUSY_LEN);
    e = sb.pop_front();
    check("ovf", bus.ovf, e.ovf);
    read_digits("digits", e.digits);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t       e;
    logic [3:0] exp_an;

    vecs[0] = '{16'd1234,  16'h1234, 1'b0};
    vecs[1] = '{16'd65535, 16'h5535, 1'b1};
    vecs[2] = '{16'd42,    16'h0042, 1'b0};
    vecs[3] = '{16'd9999,  16'h9999, 1'b0};
    vecs[4] = '{16'd10000, 16'h0000, 1'b1};
    vecs[5] = '{16'hBEEF,  16'h8879, 1'b1};
    vecs[6] = '{16'd5678,  16'h5678, 1'b0};
    vecs[7] = '{16'd0,     16'h0000, 1'b0};

    bus.result = 16'd0;
    rst        = 1'b1;
    repeat (3) @(negedge clk);
    check_reset();

    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      exp_an = 4'b1111;
      exp_an[((k - 1) / DIV) % 4] = 1'b0;
      check("scan_an", bus.an, exp_an);
      check("scan_seg", bus.seg, 7'b1000000);
      check("idle_busy", bus.busy, 1'b0);
    end

    for (int v = 0; v < 8; v++) begin
      run_vec(vecs[v].value, DEC ? vecs[v].bcd : vecs[v].value, DEC ? vecs[v].ovf : 1'b0);
    end

`ifdef RESULT_DISPLAY_DECIMAL_EN
    // 200 arrives mid-conversion and is superseded by 300 before the next capture.
    bus.result = 16'd100;
    sb.push_back(exp_t'{16'h0100, 1'b0});
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      check("ovl_busy", bus.busy, 1'b1);
      if (c == 5) bus.result = 16'd200;
      if (c == 10) begin
        bus.result = 16'd300;
        sb.push_back(exp_t'{16'h0300, 1'b0});
      end
    end
    @(negedge clk);
    check("ovl_gap", bus.busy, 1'b0);
    e = sb.pop_front();
    check("ovl_ovf", bus.ovf, e.ovf);
    read_digits("ovl_first", e.digits);
    check("ovl_second_busy", bus.busy, 1'b1);
    wait_idle("ovl_idle");
    e = sb.pop_front();
    read_digits("ovl_second", e.digits);

    // Reset at the eighth shift of a 9999 conversion.
    bus.result = 16'd9999;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset();
    rst = 1'b0;
    sb.push_back(exp_t'{16'h9999, 1'b0});
    read_digits("rst_zero", 16'h0000);
    wait_idle("rst_idle");
    e = sb.pop_front();
    check("rst_ovf_after", bus.ovf, e.ovf);
    read_digits("rst_final", e.digits);
`else
    // Second change lands while the first is loading; it must be taken one cycle later.
    bus.result = 16'h1111;
    sb.push_back(exp_t'{16'h1111, 1'b0});
    @(negedge clk);
    check("b2b_busy1", bus.busy, 1'b1);
    bus.result = 16'h2222;
    sb.push_back(exp_t'{16'h2222, 1'b0});
    @(negedge clk);
    check("b2b_gap", bus.busy, 1'b0);
    @(negedge clk);
    check("b2b_busy2", bus.busy, 1'b1);
    e = sb.pop_front();
    check("b2b_first", bus.seg, seg_of(e.digits[3:0]));
    @(negedge clk);
    check("b2b_done", bus.busy, 1'b0);
    e = sb.pop_front();
    read_digits("b2b_second", e.digits);

    // Reset on the load edge must leave the digits cleared.
    bus.result = 16'hABCD;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset();
    bus.result = 16'h0000;
    rst        = 1'b0;
    read_digits("rst_zero", 16'h0000);
    run_vec(16'h9999, 16'h9999, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
